stepper_seq_ctrl: RTL and testbench

//  Command-driven 4-coil unipolar stepper sequencer with a programmable step rate.

---
 rtl/stepper_seq_ctrl_if.sv | 37 +++
 rtl/stepper_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_stepper_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stepper_seq_ctrl_if.sv
// stepper_seq_ctrl_if
//   Command/status bundle between the motion-control logic (master) and the
//   stepper sequencer (slave).
//   master drives: cmd_valid, cmd_steps, cmd_dir, cmd_mode, step_period,
//                  hold_en, abort
//   slave drives:  cmd_ready, coil, busy, done, aborted, position
interface stepper_seq_ctrl_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [1:0]       cmd_mode;
    logic [DIV_W-1:0] step_period;
    logic             hold_en;
    logic             abort;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [POS_W-1:0] position;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_mode, step_period,
               hold_en, abort,
        input  cmd_ready, coil, busy, done, aborted, position
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_mode, step_period,
               hold_en, abort,
        output cmd_ready, coil, busy, done, aborted, position
    );
endinterface

// File: rtl/stepper_seq_ctrl.sv
// stepper_seq_ctrl
//   Command-driven 4-coil unipolar stepper sequencer. A move command (step
//   count, direction, drive mode, step period) is accepted over valid/ready
//   while idle, then one step is issued every step_period clocks. Supports
//   wave, full-step and half-step drive and tracks a signed position.
// Ports
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : stepper_seq_ctrl_if.slave
//          cmd_valid/cmd_ready handshake, cmd_steps, cmd_dir (0 fwd, 1 rev),
//          cmd_mode (00 wave, 01 full, 1x half), step_period (0 acts as 1),
//          hold_en, abort; outputs coil (registered), busy, done (1-cycle
//          pulse), aborted (valid with done), position (two's complement).
module stepper_seq_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    stepper_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] remaining;
    logic [DIV_W-1:0] tick;
    logic [DIV_W-1:0] period_m1;
    logic             dir_q;
    logic             half_q;
    logic [2:0]       idx;
    logic [2:0]       idx_step;
    logic [3:0]       coil_q;
    logic [3:0]       last_pat;
    logic [POS_W-1:0] pos_q;
    logic             aborted_q;

    logic             accept;
    logic             step;

    // Phase table: 1000 1100 0100 0110 0010 0011 0001 1001
    function automatic logic [3:0] phase_pat(input logic [2:0] i);
        logic [3:0] p;
        unique case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1100;
            3'd2:    p = 4'b0100;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0010;
            3'd5:    p = 4'b0011;
            3'd6:    p = 4'b0001;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    // Wave uses even (single-coil) entries, full uses odd (two-coil) entries.
    function automatic logic [2:0] align_idx(input logic [2:0] i,
                                             input logic [1:0] mode);
        logic [2:0] a;
        unique case (mode)
            2'b00:   a = {i[2:1], 1'b0};
            2'b01:   a = {i[2:1], 1'b1};
            default: a = i;
        endcase
        return a;
    endfunction

    assign accept = (state == IDLE) && bus.cmd_valid;
    // abort takes priority over a step due on the same edge
    assign step   = (state == RUN) && !bus.abort && (tick == period_m1);

    always_comb begin
        logic [2:0] inc;
        inc = half_q ? 3'd1 : 3'd2;
        idx_step = dir_q ? (idx - inc) : (idx + inc);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = (bus.cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nxt = DONE;
                end else if (step && (remaining == CNT_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        unique case (state)
            IDLE:    bus.cmd_ready = 1'b1;
            RUN:     bus.busy      = 1'b1;
            DONE:    bus.done      = 1'b1;
            default: ;
        endcase
    end

    // Move datapath: command latch, step timer, phase index, position, coils
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            tick      <= '0;
            period_m1 <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            idx       <= '0;
            coil_q    <= '0;
            last_pat  <= '0;
            pos_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (accept) begin
                remaining <= bus.cmd_steps;
                dir_q     <= bus.cmd_dir;
                half_q    <= bus.cmd_mode[1];
                period_m1 <= (bus.step_period == '0) ? '0
                                                     : bus.step_period - DIV_W'(1);
                tick      <= '0;
                idx       <= align_idx(idx, bus.cmd_mode);
                aborted_q <= 1'b0;
            end

            if (state == RUN) begin
                if (bus.abort) begin
                    aborted_q <= 1'b1;
                end
                if (step) begin
                    tick      <= '0;
                    idx       <= idx_step;
                    coil_q    <= phase_pat(idx_step);
                    last_pat  <= phase_pat(idx_step);
                    remaining <= remaining - CNT_W'(1);
                    pos_q     <= dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
                end else begin
                    tick <= tick + DIV_W'(1);
                end
            end else begin
                // Outside RUN the coils follow hold_en every cycle
                coil_q <= bus.hold_en ? last_pat : '0;
            end
        end
    end

    assign bus.coil     = coil_q;
    assign bus.aborted  = aborted_q;
    assign bus.position = pos_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
module tb_stepper_seq_ctrl;
    localparam int DIV_W = 16;
    localparam int CNT_W = 16;
    localparam int POS_W = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stepper_seq_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();

    stepper_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase index, position, last energised pattern
    logic [3:0] phase_tbl [8];
    int         m_idx;
    int         m_pos;
    logic [3:0] m_last;

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_steps   = '0;
        bus.cmd_dir     = 1'b0;
        bus.cmd_mode    = 2'b00;
        bus.step_period = '0;
        bus.hold_en     = 1'b1;
        bus.abort       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0; m_pos = 0; m_last = 4'b0000;
        #1;
        n_checks++; if (bus.coil !== 4'b0000) $display("FAIL reset_coil got %b want 0000", bus.coil); else n_pass++;
        n_checks++; if (bus.position !== '0) $display("FAIL reset_pos got %0h want 0", bus.position); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.aborted !== 1'b0) $display("FAIL reset_aborted got %b want 0", bus.aborted); else n_pass++;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.cmd_ready); else n_pass++;
    endtask

    // Issues one command and checks every cycle from accept to return to idle.
    // abort_at = edge index (1 = first edge after accept) sampling abort=1; 0 = none.
    task automatic test_move(input int n, input int dir, input int mode, input int per,
                             input int abort_at, input logic hold, input string tag);
        int p, inc, sgn, aligned, taken, end_c, k, idx_k;
        bit ab;
        logic [3:0] pre, exp_coil;
        logic [POS_W-1:0] exp_pos;
        p       = (per == 0) ? 1 : per;
        inc     = (mode >= 2) ? 1 : 2;
        sgn     = (dir != 0) ? -1 : 1;
        aligned = (mode == 0) ? (m_idx & 6) : (mode == 1) ? (m_idx | 1) : m_idx;
        ab      = (n > 0) && (abort_at >= 1) && (abort_at <= n * p);
        end_c   = ab ? abort_at : n * p;
        taken   = ab ? (abort_at - 1) / p : n;
        pre     = hold ? m_last : 4'b0000;

        @(negedge clk);
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL %s ready_before got %b want 1", tag, bus.cmd_ready); else n_pass++;
        bus.cmd_valid   = 1'b1;
        bus.cmd_steps   = CNT_W'(n);
        bus.cmd_dir     = dir[0];
        bus.cmd_mode    = 2'(mode);
        bus.step_period = DIV_W'(per);
        bus.hold_en     = hold;
        bus.abort       = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;

        for (int c = 0; c <= end_c + 1; c++) begin
            k = c / p;
            if (k > taken) k = taken;
            idx_k = (((aligned + sgn * k * inc) % 8) + 8) % 8;
            if (c <= end_c) exp_coil = (k > 0) ? phase_tbl[idx_k] : pre;
            else            exp_coil = hold ? ((k > 0) ? phase_tbl[idx_k] : m_last) : 4'b0000;
            exp_pos = POS_W'(m_pos + sgn * k);

            n_checks++; if (bus.coil !== exp_coil) $display("FAIL %s coil c=%0d got %b want %b", tag, c, bus.coil, exp_coil); else n_pass++;
            n_checks++; if (bus.position !== exp_pos) $display("FAIL %s pos c=%0d got %0h want %0h", tag, c, bus.position, exp_pos); else n_pass++;
            n_checks++; if (bus.busy !== ((n > 0) && (c < end_c))) $display("FAIL %s busy c=%0d got %b want %b", tag, c, bus.busy, ((n > 0) && (c < end_c))); else n_pass++;
            n_checks++; if (bus.done !== (c == end_c)) $display("FAIL %s done c=%0d got %b want %b", tag, c, bus.done, (c == end_c)); else n_pass++;
            n_checks++; if (bus.cmd_ready !== (c > end_c)) $display("FAIL %s ready c=%0d got %b want %b", tag, c, bus.cmd_ready, (c > end_c)); else n_pass++;
            if (c == end_c) begin
                n_checks++; if (bus.aborted !== ab) $display("FAIL %s aborted got %b want %b", tag, bus.aborted, ab); else n_pass++;
            end

            if (c <= end_c) begin
                @(negedge clk);
                bus.abort       = (c + 1 == abort_at);
                // Command inputs are junk while busy; they must not matter
                bus.step_period = DIV_W'($urandom);
                bus.cmd_steps   = CNT_W'($urandom);
                bus.cmd_dir     = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        bus.abort = 1'b0;

        m_idx = (((aligned + sgn * taken * inc) % 8) + 8) % 8;
        m_pos = m_pos + sgn * taken;
        if (taken > 0) m_last = phase_tbl[m_idx];
    endtask

    task automatic test_hold;
        test_move(3, 0, 2, 2, 0, 1'b0, "hold_off_move");
        @(negedge clk);
        bus.hold_en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bus.coil !== m_last) $display("FAIL hold_on coil got %b want %b", bus.coil, m_last); else n_pass++;
        @(negedge clk);
        bus.hold_en = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (bus.coil !== 4'b0000) $display("FAIL hold_off coil got %b want 0000", bus.coil); else n_pass++;
        @(negedge clk);
        bus.hold_en = 1'b1;
    endtask

    task automatic test_random;
        int n, per, mode, dir, p, ab;
        logic hold;
        for (int it = 0; it < 16; it++) begin
            n    = $urandom_range(0, 5);
            per  = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            dir  = $urandom_range(0, 1);
            hold = 1'($urandom);
            p    = (per == 0) ? 1 : per;
            ab   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * p + 1) : 0;
            test_move(n, dir, mode, per, ab, hold, "random");
        end
    endtask

    task automatic test_reset_mid_move;
        @(negedge clk);
        bus.hold_en     = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_steps   = CNT_W'(50);
        bus.cmd_dir     = 1'b0;
        bus.cmd_mode    = 2'b10;
        bus.step_period = DIV_W'(2);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL rst_mid busy_before got %b want 1", bus.busy); else n_pass++;
        rst = 1'b1;
        #1;
        m_idx = 0; m_pos = 0; m_last = 4'b0000;
        n_checks++; if (bus.coil !== 4'b0000) $display("FAIL rst_mid coil got %b want 0000", bus.coil); else n_pass++;
        n_checks++; if (bus.position !== '0) $display("FAIL rst_mid pos got %0h want 0", bus.position); else n_pass++;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_mid ready got %b want 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_mid busy got %b want 0", bus.busy); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_mid done c=%0d got %b want 0", c, bus.done); else n_pass++;
        end
    endtask

    initial begin
        phase_tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                      4'b0010, 4'b0011, 4'b0001, 4'b1001};
        test_reset;
        test_move(8,   0, 2, 4,  0,  1'b1, "half_fwd");
        test_move(3,   1, 1, 1,  0,  1'b1, "full_rev");
        test_move(100, 0, 0, 10, 25, 1'b1, "wave_abort");
        test_move(0,   0, 2, 3,  0,  1'b1, "zero_steps");
        test_hold;
        test_move(4,   1, 3, 0,  0,  1'b1, "mode3_per0");
        test_move(3,   0, 2, 3,  6,  1'b1, "abort_on_step");
        test_random;
        test_reset_mid_move;
        test_move(2,   0, 1, 2,  0,  1'b1, "after_reset");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
